// File: rtl/multicycle_cpu.sv
// Multicycle core: FETCH/DECODE/EXECUTE/MEM/WB sequencer with internal register file,
// ALU and N/Z flags; instruction and data memories sit behind req/ready handshakes.
module multicycle_cpu #(
    parameter int              XLEN     = 32,
    parameter int              NREG     = 16,
    parameter logic [XLEN-1:0] PC_RESET = '0
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ready,
    input  logic [31:0]     imem_rdata,
    output logic            dmem_req,
    output logic            dmem_we,
    output logic [XLEN-1:0] dmem_addr,
    output logic [XLEN-1:0] dmem_wdata,
    input  logic            dmem_ready,
    input  logic [XLEN-1:0] dmem_rdata,
    output logic [XLEN-1:0] pc,
    output logic            halted
);
    localparam int RW = $clog2(NREG);
    localparam int SW = $clog2(XLEN);

    typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXECUTE, S_MEM, S_WB, S_HALT} state_t;

    state_t          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [31:0]     ir_q, ir_d;
    logic [XLEN-1:0] a_q, a_d, b_q, b_d, d_q, d_d;
    logic [XLEN-1:0] alu_q, alu_d, mdr_q, mdr_d;
    logic            n_q, n_d, z_q, z_d;
    logic [XLEN-1:0] regs_q [NREG];
    logic [XLEN-1:0] regs_d [NREG];

    logic [3:0]      op;
    logic [RW-1:0]   rd_idx, rn_idx, rm_idx;
    logic [XLEN-1:0] imm_ext, pc_plus4, br_target, alu_res;
    logic            taken;

    assign op        = ir_q[31:28];
    assign rd_idx    = ir_q[24 +: RW];
    assign rn_idx    = ir_q[20 +: RW];
    assign rm_idx    = ir_q[16 +: RW];
    assign imm_ext   = XLEN'($signed(ir_q[15:0]));
    assign pc_plus4  = pc_q + XLEN'(4);
    assign br_target = pc_plus4 + (imm_ext << 2);

    // ALU result and branch decision; the condition uses the flags held before EXECUTE
    always_comb begin
        alu_res = '0;
        case (op)
            4'h0:    alu_res = a_q + b_q;
            4'h1:    alu_res = a_q - b_q;
            4'h2:    alu_res = a_q & b_q;
            4'h3:    alu_res = a_q | b_q;
            4'h4:    alu_res = a_q ^ b_q;
            4'h5:    alu_res = a_q + imm_ext;
            4'h6:    alu_res = a_q << b_q[SW-1:0];
            4'h7:    alu_res = a_q - b_q;
            default: alu_res = '0;
        endcase
        taken = 1'b0;
        case (op)
            4'hA:    taken = 1'b1;
            4'hB:    taken = z_q;
            4'hC:    taken = ~z_q;
            4'hD:    taken = n_q;
            4'hE:    taken = ~n_q;
            default: taken = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_FETCH;
            pc_q    <= PC_RESET;
            ir_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            d_q     <= '0;
            alu_q   <= '0;
            mdr_q   <= '0;
            n_q     <= 1'b0;
            z_q     <= 1'b0;
            regs_q  <= '{default: '0};
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            a_q     <= a_d;
            b_q     <= b_d;
            d_q     <= d_d;
            alu_q   <= alu_d;
            mdr_q   <= mdr_d;
            n_q     <= n_d;
            z_q     <= z_d;
            regs_q  <= regs_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:   if (imem_ready) state_d = S_DECODE;
            S_DECODE:  state_d = S_EXECUTE;
            S_EXECUTE: begin
                if (op <= 4'h6)                    state_d = S_WB;
                else if (op == 4'h8 || op == 4'h9) state_d = S_MEM;
                else if (op == 4'hF)               state_d = S_HALT;
                else                               state_d = S_FETCH;
            end
            S_MEM:     if (dmem_ready) state_d = (op == 4'h8) ? S_WB : S_FETCH;
            S_WB:      state_d = S_FETCH;
            default:   state_d = S_HALT;
        endcase
    end

    always_comb begin
        pc_d   = pc_q;
        ir_d   = ir_q;
        a_d    = a_q;
        b_d    = b_q;
        d_d    = d_q;
        alu_d  = alu_q;
        mdr_d  = mdr_q;
        n_d    = n_q;
        z_d    = z_q;
        regs_d = regs_q;
        case (state_q)
            S_FETCH: if (imem_ready) ir_d = imem_rdata;
            S_DECODE: begin
                a_d = regs_q[rn_idx];
                b_d = regs_q[rm_idx];
                d_d = regs_q[rd_idx];
            end
            S_EXECUTE: begin
                if (op <= 4'h7) begin
                    n_d = alu_res[XLEN-1];
                    z_d = (alu_res == '0);
                end
                if (op <= 4'h6)
                    alu_d = alu_res;
                else if (op == 4'h8 || op == 4'h9)
                    alu_d = a_q + imm_ext;
                else if (op == 4'h7)
                    pc_d = pc_plus4;
                else if (op != 4'hF)
                    pc_d = taken ? br_target : pc_plus4;
            end
            S_MEM: begin
                if (dmem_ready && op == 4'h8) mdr_d = dmem_rdata;
                if (dmem_ready && op == 4'h9) pc_d  = pc_plus4;
            end
            S_WB: begin
                if (rd_idx != '0) regs_d[rd_idx] = (op == 4'h8) ? mdr_q : alu_q;
                pc_d = pc_plus4;
            end
            default: ;
        endcase
    end

    // Requests are gated by rst so an in-flight access is dropped the moment reset rises
    always_comb begin
        imem_req   = 1'b0;
        dmem_req   = 1'b0;
        dmem_we    = 1'b0;
        dmem_addr  = '0;
        dmem_wdata = '0;
        if (!rst) begin
            case (state_q)
                S_FETCH: imem_req = 1'b1;
                S_MEM: begin
                    dmem_req   = 1'b1;
                    dmem_we    = (op == 4'h9);
                    dmem_addr  = alu_q;
                    dmem_wdata = d_q;
                end
                default: ;
            endcase
        end
    end

    assign imem_addr = pc_q;
    assign pc        = pc_q;
    assign halted    = (state_q == S_HALT);

endmodule

// File: tb/tb_multicycle_cpu.sv
// Directed bench for multicycle_cpu: a 32-bit core running a small program from 0x100
// with a wait-state data memory, plus a 16-bit core checking overflow into the sign bit.
module tb_multicycle_cpu;
    logic        clk;
    logic        rst;
    logic        imem_req, imem_ready, dmem_req, dmem_we, dmem_ready, halted;
    logic [31:0] imem_addr, imem_rdata, dmem_addr, dmem_wdata, dmem_rdata, pc;

    logic        imem16_req, dmem16_req, dmem16_we, halted16;
    logic [15:0] imem16_addr, dmem16_addr, dmem16_wdata, pc16;
    logic [31:0] imem16_rdata;

    logic [31:0] imem   [0:127];
    logic [31:0] imem16 [0:15];
    logic [31:0] dmem   [0:255];
    logic        dmem_clear;
    int          dmem_wait;
    int          dcnt;
    logic [15:0] st16_data, st16_addr;

    int checks = 0;
    int errors = 0;

    multicycle_cpu #(.XLEN(32), .NREG(16), .PC_RESET(32'h100)) dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready), .imem_rdata(imem_rdata),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata), .pc(pc), .halted(halted)
    );

    multicycle_cpu #(.XLEN(16), .NREG(16), .PC_RESET(16'h0)) dut16 (
        .clk(clk), .rst(rst),
        .imem_req(imem16_req), .imem_addr(imem16_addr), .imem_ready(imem16_req), .imem_rdata(imem16_rdata),
        .dmem_req(dmem16_req), .dmem_we(dmem16_we), .dmem_addr(dmem16_addr), .dmem_wdata(dmem16_wdata),
        .dmem_ready(dmem16_req), .dmem_rdata(16'h0), .pc(pc16), .halted(halted16)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Zero-wait instruction memories; data memory adds dmem_wait stall cycles per access
    assign imem_ready   = imem_req;
    assign imem_rdata   = imem[7'((imem_addr - 32'h100) >> 2)];
    assign imem16_rdata = imem16[imem16_addr[5:2]];
    assign dmem_ready   = dmem_req && (dcnt >= dmem_wait);
    assign dmem_rdata   = dmem[dmem_addr[9:2]];

    always @(posedge clk or posedge rst) begin
        if (rst)                         dcnt <= 0;
        else if (dmem_req && !dmem_ready) dcnt <= dcnt + 1;
        else                             dcnt <= 0;
    end

    always @(posedge clk) begin
        if (dmem_clear) begin
            for (int i = 0; i < 256; i++) dmem[i] <= 32'hDEAD_BEEF;
        end else if (dmem_req && dmem_ready && dmem_we) begin
            dmem[dmem_addr[9:2]] <= dmem_wdata;
        end
    end

    always @(posedge clk) begin
        if (dmem16_req && dmem16_we) begin
            st16_data <= dmem16_wdata;
            st16_addr <= dmem16_addr;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
        end
    endtask

    task automatic stepInstr(output int cyc);
        logic [31:0] old_pc;
        old_pc = pc;
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (pc == old_pc && cyc < 60);
        if (pc == old_pc) checkOutput("step_timeout", 32'(cyc), 32'd0);
    endtask

    logic [31:0] exp_pc  [16] = '{32'h118, 32'h124, 32'h128, 32'h12C, 32'h130, 32'h134, 32'h138, 32'h13C,
                                  32'h144, 32'h148, 32'h14C, 32'h150, 32'h154, 32'h158, 32'h15C, 32'h164};
    int          exp_cyc [16] = '{3, 3, 3, 4, 4, 4, 4, 4, 3, 3, 4, 4, 3, 4, 4, 3};

    initial begin
        int cyc;
        for (int i = 0; i < 128; i++) imem[i] = 32'hF000_0000;
        for (int i = 0; i < 16; i++)  imem16[i] = 32'hF000_0000;
        imem[0]  = 32'h5100_0005;  imem[1]  = 32'h5200_FFFD;  imem[2]  = 32'h0312_0000;
        imem[3]  = 32'h9300_0040;  imem[4]  = 32'h8400_0040;  imem[5]  = 32'h7011_0000;
        imem[6]  = 32'hB000_0002;  imem[9]  = 32'hC000_0002;  imem[10] = 32'h5000_0007;
        imem[11] = 32'h0500_0000;  imem[12] = 32'h9400_0044;  imem[13] = 32'h9500_0048;
        imem[14] = 32'h0612_0000;  imem[15] = 32'hC000_0001;  imem[17] = 32'hD000_0001;
        imem[18] = 32'h9300_004C;  imem[19] = 32'h1721_0000;  imem[20] = 32'hE000_0001;
        imem[21] = 32'h6811_0000;  imem[22] = 32'h9800_0050;  imem[23] = 32'hA000_0001;
        imem16[0] = 32'h5100_7FFF; imem16[1] = 32'h5110_0001; imem16[2] = 32'hD000_0001;
        imem16[4] = 32'h9100_0020;

        rst = 1'b1;
        dmem_clear = 1'b1;
        dmem_wait = 0;
        @(negedge clk);
        checkOutput("rst_pc", pc, 32'h100);
        checkOutput("rst_imem_req", 32'(imem_req), 32'd0);
        checkOutput("rst_dmem_req", 32'(dmem_req), 32'd0);
        checkOutput("rst_halted", 32'(halted), 32'd0);
        dmem_clear = 1'b0;
        rst = 1'b0;
        #1;
        checkOutput("first_imem_req", 32'(imem_req), 32'd1);
        checkOutput("first_imem_addr", imem_addr, 32'h100);

        stepInstr(cyc); checkOutput("addi1_pc", pc, 32'h104); checkOutput("addi1_cyc", 32'(cyc), 32'd4);
        stepInstr(cyc); checkOutput("addi2_pc", pc, 32'h108); checkOutput("addi2_cyc", 32'(cyc), 32'd4);
        stepInstr(cyc); checkOutput("add_pc", pc, 32'h10C);   checkOutput("add_cyc", 32'(cyc), 32'd4);

        dmem_wait = 3;
        cyc = 0;
        while (!dmem_req && cyc < 60) begin
            @(negedge clk);
            cyc++;
        end
        checkOutput("str_mem_entry", 32'(cyc), 32'd3);
        for (int i = 0; i < 4; i++) begin
            checkOutput("str_req", 32'(dmem_req), 32'd1);
            checkOutput("str_addr", dmem_addr, 32'h40);
            checkOutput("str_we", 32'(dmem_we), 32'd1);
            checkOutput("str_wdata", dmem_wdata, 32'd2);
            checkOutput("str_imem_idle", 32'(imem_req), 32'd0);
            @(negedge clk);
        end
        checkOutput("str_pc", pc, 32'h110);
        stepInstr(cyc); checkOutput("ldr_pc", pc, 32'h114); checkOutput("ldr_cyc", 32'(cyc), 32'd8);

        dmem_wait = 0;
        for (int i = 0; i < 16; i++) begin
            stepInstr(cyc);
            checkOutput($sformatf("prog_pc_%0d", i), pc, exp_pc[i]);
            checkOutput($sformatf("prog_cyc_%0d", i), 32'(cyc), 32'(exp_cyc[i]));
        end

        cyc = 0;
        while (!halted && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        checkOutput("halted", 32'(halted), 32'd1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checkOutput("halt_no_fetch", 32'(imem_req), 32'd0);
        end
        checkOutput("halt_pc", pc, 32'h164);
        checkOutput("mem_r3", dmem[16], 32'd2);
        checkOutput("mem_r4_ldr", dmem[17], 32'd2);
        checkOutput("mem_r5_r0zero", dmem[18], 32'd0);
        checkOutput("mem_r3_again", dmem[19], 32'd2);
        checkOutput("mem_lsl", dmem[20], 32'hA0);

        checkOutput("x16_store_data", 32'(st16_data), 32'h8000);
        checkOutput("x16_store_addr", 32'(st16_addr), 32'h20);
        checkOutput("x16_halted", 32'(halted16), 32'd1);
        checkOutput("x16_pc", 32'(pc16), 32'h14);

        #2 rst = 1'b1;
        #1;
        checkOutput("halt_rst_halted", 32'(halted), 32'd0);
        checkOutput("halt_rst_pc", pc, 32'h100);
        checkOutput("halt_rst_imem_req", 32'(imem_req), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        checkOutput("restart_imem_req", 32'(imem_req), 32'd1);
        checkOutput("restart_imem_addr", imem_addr, 32'h100);

        dmem_wait = 20;
        cyc = 0;
        while (!dmem_req && cyc < 60) begin
            @(negedge clk);
            cyc++;
        end
        checkOutput("midmem_req", 32'(dmem_req), 32'd1);
        #2 rst = 1'b1;
        #1;
        checkOutput("midmem_rst_req", 32'(dmem_req), 32'd0);
        checkOutput("midmem_rst_we", 32'(dmem_we), 32'd0);
        checkOutput("midmem_rst_addr", dmem_addr, 32'd0);
        checkOutput("midmem_rst_pc", pc, 32'h100);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("post_rst_pc", pc, 32'h100);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/multicycle_cpu.md
Name: multicycle_cpu

Overview:
- Parametrised multicycle successor to the team's single-cycle core.
- Runs a FETCH/DECODE/EXECUTE/MEM/WB state machine with an internal register file, ALU and N/Z flags.
- Instruction and data memory are external, each on a req/ready handshake, so memories with wait states can be attached.
- Adds conditional branches, load/store stalls and a HALT state.

Parameters:
- XLEN, 32, datapath and address width (>=16).
- NREG, 16, register count (power of 2, <=16); r0 reads 0, writes to r0 are ignored.
- PC_RESET, 0, PC value after reset (word aligned).

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- imem_req  out  1  instruction fetch request.
- imem_addr  out  XLEN  fetch address; equals pc.
- imem_ready  in  1  fetch complete; imem_rdata valid this cycle.
- imem_rdata  in  32  instruction word.
- dmem_req  out  1  data access request.
- dmem_we  out  1  1 = store, 0 = load.
- dmem_addr  out  XLEN  data address.
- dmem_wdata  out  XLEN  store data.
- dmem_ready  in  1  access complete; dmem_rdata valid for loads.
- dmem_rdata  in  XLEN  load data.
- pc  out  XLEN  current instruction address.
- halted  out  1  core stopped in HALT.

Behaviour:
- Instruction encoding: op=[31:28], rd=[27:24], rn=[23:20], rm=[19:16], imm=[15:0].
  - imm is sign-extended to XLEN.
  - Register indices are truncated to log2(NREG) bits.
- Opcodes:
  - 0 ADD rd=rn+rm; 1 SUB rd=rn-rm; 2 AND; 3 OR; 4 XOR.
  - 5 ADDI rd=rn+imm.
  - 6 LSL rd=rn<<rm[log2(XLEN)-1:0].
  - 7 CMP: computes rn-rm, no writeback.
  - 8 LDR rd=mem[rn+imm]; 9 STR mem[rn+imm]=rd.
  - A B (always); B BEQ (Z); C BNE (~Z); D BLT (N); E BGE (~N).
  - F HALT.
- Arithmetic is modulo 2^XLEN. Flags: N = result MSB, Z = (result==0).
  - Opcodes 0-7 update flags in EXECUTE.
  - All other opcodes leave flags unchanged.
- Branch target = pc+4+(imm<<2). A not-taken branch gives pc+4.
- Reset (async, any state): state=FETCH, pc=PC_RESET, all registers=0, N=Z=0, halted=0.
  - imem_req and dmem_req are forced 0 while rst=1. dmem_we=0, addresses/wdata=0.
  - Reset mid-transaction abandons the access with no retry bookkeeping.
- FETCH:
  - imem_req=1, imem_addr=pc.
  - On a posedge with imem_ready=1: IR<=imem_rdata, go to DECODE.
  - Zero-wait fetch (ready in the first req cycle) is legal.
- DECODE: operand registers A<=R[rn], B<=R[rm], D<=R[rd]; go to EXECUTE.
- EXECUTE:
  - ALU ops (0-6): ALUOut<=result, go to WB.
  - CMP: pc<=pc+4, go to FETCH.
  - LDR/STR: ALUOut<=A+imm, go to MEM.
  - Branches: pc<=taken?target:pc+4, go to FETCH. The condition uses flags as they are before this cycle.
  - HALT: go to HALT.
- MEM:
  - dmem_req=1, dmem_addr=ALUOut, dmem_we=(op==STR), dmem_wdata=D.
  - These values are held stable until a posedge with dmem_ready=1.
  - On completion, a load latches MDR<=dmem_rdata and goes to WB.
  - On completion, a store sets pc<=pc+4 and goes to FETCH.
- WB: R[rd]<=(LDR?MDR:ALUOut) unless rd==0; pc<=pc+4; go to FETCH.
- HALT: halted=1, no requests; the core stays here until rst.
- Ready inputs sampled while the matching req=0 are ignored. req never drops before ready.
- Latency with zero-wait memories:
  - ALU op 4 cycles; CMP/branch 3 cycles.
  - LDR 5 cycles; STR 4 cycles.
- The instruction memory is expected to return word-aligned pc values. dmem_addr is passed through with no alignment check.

Test Plan:
- Reset with PC_RESET=0x100 -> pc=0x100; first imem_addr=0x100 after rst falls; imem_req=0, dmem_req=0, halted=0 during rst.
- ADDI r1,r0,5; ADDI r2,r0,-3; ADD r3,r1,r2 with zero-wait imem -> r3=2, N=0, Z=0; 4 cycles per instruction; final pc=+12.
- CMP r1,r1; BEQ imm=2 -> Z=1, branch taken, pc = branch pc+4+8. Repeat with BNE -> not taken, pc+4.
- STR r3,[r0+0x40] then LDR r4,[r0+0x40] with dmem_ready delayed 3 cycles -> dmem_addr=0x40, wdata=2, we=1 held stable for 3 cycles; r4=2; imem_req low throughout MEM.
- ADDI r0,r0,7 then ADD r5,r0,r0 -> r5=0, r0 write suppressed; XLEN=16 build: ADDI r1,r0,0x7FFF; ADDI r1,r1,1 -> r1=0x8000, N=1.
- HALT -> halted=1 and no further imem_req; assert rst while in HALT -> halted=0 and fetch restarts at PC_RESET; rst asserted mid-MEM -> dmem_req drops asynchronously.
